// File: rtl/dem_seq_pkg.sv
// Shared types and helpers for the counter sequence checker (dem_seq_checker).
package dem_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } seq_state_t;

  // Next value of a modulo-'modulus' up-counter.
  function automatic int unsigned succ(input int unsigned v, input int unsigned modulus);
    return (v == modulus - 32'd1) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/dem_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module dem_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rs,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rs)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dem_seq_checker.sv
// Monitor that locks onto a modulo-MODULUS counter sequence and flags broken transitions.
// Optional macro DEM_SEQ_CHK_RESTART_EN: accept a jump to 0 while locked as a legal counter reset.
module dem_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int LOCK_CNT = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rs,
  input  logic                en,
  input  logic [WIDTH-1:0]    q_in,
  output logic                locked,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0]    exp_q
);
  import dem_seq_pkg::*;

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH:0]  MOD_LIM  = (WIDTH + 1)'(MODULUS);
  localparam logic [GOOD_W-1:0] GOOD_LIM = GOOD_W'(LOCK_CNT);

  seq_state_t        state, state_d;
  logic [GOOD_W-1:0] good, good_d;
  logic [WIDTH-1:0]  exp_d;
  logic              err_d;

  logic              out_of_range;
  logic              match;
  logic              restart_ok;
  logic [WIDTH-1:0]  q_succ;

  assign out_of_range = ({1'b0, q_in} >= MOD_LIM);
  assign match        = (q_in == exp_q);
  assign q_succ       = WIDTH'(succ(32'(q_in), MODULUS));

`ifdef DEM_SEQ_CHK_RESTART_EN
  assign restart_ok = (q_in == '0) && (exp_q != '0);
`else
  assign restart_ok = 1'b0;
`endif

  // Out-of-range samples are fatal to sync in every state; otherwise each
  // in-range sample re-seeds the expectation so we track the counter wherever it went.
  always_comb begin
    state_d = state;
    good_d  = good;
    exp_d   = exp_q;
    err_d   = 1'b0;
    if (en) begin
      if (out_of_range) begin
        err_d   = 1'b1;
        state_d = IDLE;
        good_d  = '0;
      end else begin
        exp_d = q_succ;
        unique case (state)
          IDLE: begin
            state_d = SYNC;
            good_d  = '0;
          end
          SYNC: begin
            if (match) begin
              if (good + 1'b1 >= GOOD_LIM) begin
                state_d = LOCKED;
                good_d  = '0;
              end else begin
                good_d = good + 1'b1;
              end
            end else begin
              good_d = '0;
            end
          end
          LOCKED: begin
            if (!match && !restart_ok) begin
              err_d   = 1'b1;
              state_d = SYNC;
              good_d  = '0;
            end
          end
          default: begin
            state_d = IDLE;
            good_d  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state <= IDLE;
      good  <= '0;
      exp_q <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      good  <= good_d;
      exp_q <= exp_d;
      err   <= err_d;
    end
  end

  assign locked = (state == LOCKED);

  dem_sat_cnt #(.W(ERRCNT_W)) u_err_cnt (
    .clk (clk),
    .rs  (rs),
    .inc (err_d),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_dem_seq_checker.sv
// Self-checking bench for dem_seq_checker: a default build and a MODULUS=10 / ERRCNT_W=2 build share stimulus.
module tb_dem_seq_checker;

  localparam int LOCK_CNT = 2;

  logic       clk = 1'b0;
  logic       rs;
  logic       en;
  logic [3:0] q_in;

  logic       locked_a, err_a;
  logic [7:0] err_cnt_a;
  logic [3:0] exp_q_a;
  logic       locked_b, err_b;
  logic [1:0] err_cnt_b;
  logic [3:0] exp_q_b;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, one slot per instance (0 = default, 1 = mod-10).
  int m_mod[2];
  int m_cntmax[2];
  bit m_has_last[2];
  bit m_exp_known[2];
  bit m_locked[2];
  bit m_err[2];
  int m_exp[2];
  int m_streak[2];
  int m_cnt[2];

  always #5 clk = ~clk;

  dem_seq_checker #(.WIDTH(4), .MODULUS(16), .LOCK_CNT(LOCK_CNT), .ERRCNT_W(8)) dut_a (
    .clk(clk), .rs(rs), .en(en), .q_in(q_in),
    .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a), .exp_q(exp_q_a)
  );

  dem_seq_checker #(.WIDTH(4), .MODULUS(10), .LOCK_CNT(LOCK_CNT), .ERRCNT_W(2)) dut_b (
    .clk(clk), .rs(rs), .en(en), .q_in(q_in),
    .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b), .exp_q(exp_q_b)
  );

  // Behavioural model: a run of correct transitions earns lock, a broken one while locked costs an error.
  task automatic modelStep(input bit rs_v, input bit en_v, input int q);
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 1'b0;
      if (rs_v) begin
        m_has_last[i]  = 1'b0;
        m_exp_known[i] = 1'b1;
        m_locked[i]    = 1'b0;
        m_exp[i]       = 0;
        m_streak[i]    = 0;
        m_cnt[i]       = 0;
      end else if (en_v) begin
        if (q >= m_mod[i]) begin
          m_err[i]       = 1'b1;
          m_cnt[i]       = (m_cnt[i] < m_cntmax[i]) ? m_cnt[i] + 1 : m_cnt[i];
          m_has_last[i]  = 1'b0;
          m_exp_known[i] = 1'b0;
          m_locked[i]    = 1'b0;
          m_streak[i]    = 0;
        end else if (!m_has_last[i]) begin
          m_has_last[i]  = 1'b1;
          m_exp_known[i] = 1'b1;
          m_streak[i]    = 0;
          m_exp[i]       = (q + 1) % m_mod[i];
        end else if (q == m_exp[i]) begin
          m_streak[i]++;
          if (m_streak[i] >= LOCK_CNT) m_locked[i] = 1'b1;
          m_exp[i] = (q + 1) % m_mod[i];
        end else begin
`ifdef DEM_SEQ_CHK_RESTART_EN
          if (m_locked[i] && q == 0) begin
            m_exp[i] = 1;
          end else
`endif
          begin
            if (m_locked[i]) begin
              m_err[i] = 1'b1;
              m_cnt[i] = (m_cnt[i] < m_cntmax[i]) ? m_cnt[i] + 1 : m_cnt[i];
            end
            m_locked[i] = 1'b0;
            m_streak[i] = 0;
            m_exp[i]    = (q + 1) % m_mod[i];
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    chk("locked_a",  32'(locked_a),  32'(m_locked[0]));
    chk("err_a",     32'(err_a),     32'(m_err[0]));
    chk("err_cnt_a", 32'(err_cnt_a), 32'(m_cnt[0]));
    if (m_exp_known[0]) chk("exp_q_a", 32'(exp_q_a), 32'(m_exp[0]));
    chk("locked_b",  32'(locked_b),  32'(m_locked[1]));
    chk("err_b",     32'(err_b),     32'(m_err[1]));
    chk("err_cnt_b", 32'(err_cnt_b), 32'(m_cnt[1]));
    if (m_exp_known[1]) chk("exp_q_b", 32'(exp_q_b), 32'(m_exp[1]));
  endtask

  task automatic applyStimulus(input bit rs_v, input bit en_v, input int q);
    @(negedge clk);
    rs   = rs_v;
    en   = en_v;
    q_in = 4'(q);
    @(posedge clk);
    modelStep(rs_v, en_v, q);
    #1;
    checkOutput();
  endtask

  initial begin
    int q;
    m_mod[0] = 16; m_mod[1] = 10;
    m_cntmax[0] = 255; m_cntmax[1] = 3;
    rs = 1'b1; en = 1'b0; q_in = '0;

    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 7);

    // Lock on 0,1,2 then run to exp 6 and break the sequence with 9.
    for (int v = 0; v <= 5; v++) applyStimulus(0, 1, v);
    applyStimulus(0, 1, 9);
    applyStimulus(0, 1, 10);
    applyStimulus(0, 1, 11);

    // Run through the wrap point 15 -> 0.
    for (int v = 12; v <= 15; v++) applyStimulus(0, 1, v);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);

    // Jump to 0 while expecting 5.
    for (int v = 2; v <= 4; v++) applyStimulus(0, 1, v);
    applyStimulus(0, 1, 0);

    // Out-of-range for the mod-10 build while locked, then resync.
    applyStimulus(1, 0, 0);
    for (int v = 0; v <= 2; v++) applyStimulus(0, 1, v);
    applyStimulus(0, 1, 12);
    applyStimulus(0, 1, 4);
    applyStimulus(0, 1, 5);

    // Disabled cycles hold everything regardless of q_in.
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, $urandom_range(15));

    // Five locked mismatches drive the 2-bit counter into saturation; reset mid-sequence.
    applyStimulus(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      for (int v = 0; v <= 2; v++) applyStimulus(0, 1, v);
      applyStimulus(0, 1, 7);
    end
    applyStimulus(0, 1, 8);
    applyStimulus(1, 1, 9);

    // Randomized run mostly following the expected sequence.
    for (int k = 0; k < 400; k++) begin
      if (m_exp_known[0] && $urandom_range(99) < 85) q = m_exp[0];
      else q = int'($urandom_range(15));
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(9) != 0), q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
